// File: rtl/blur_mem_arbiter.sv
// blur_mem_arbiter: round-robin, lockable arbiter in front of one blurred-image
// SRAM. It multiplexes the SRAM port between the blur writers, the detector
// reader and the descriptor reader. Each read response is tagged back to its
// issuer through rvalid.
module blur_mem_arbiter #(
    parameter int N_REQ  = 3,
    parameter int ADDR_W = 9,
    parameter int DATA_W = 5120,
    parameter int DEPTH  = 480
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ-1:0]          lock,
    input  logic [N_REQ-1:0]          we,
    input  logic [N_REQ*ADDR_W-1:0]   addr,
    input  logic [N_REQ*DATA_W-1:0]   wdata,
    output logic [N_REQ-1:0]          gnt,
    output logic [N_REQ-1:0]          rvalid,
    output logic [DATA_W-1:0]         rdata,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_din,
    input  logic [DATA_W-1:0]         mem_dout,
    output logic                      busy,
    output logic                      addr_err
);

    localparam int                IDX_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W+1)'(DEPTH);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_REQ - 1);

    logic [ADDR_W-1:0] addr_a  [N_REQ];
    logic [DATA_W-1:0] wdata_a [N_REQ];

    logic [IDX_W-1:0]  rr_ptr;
    logic              owner_vld;
    logic [IDX_W-1:0]  owner_idx;

    logic [IDX_W-1:0]  sel_idx;
    logic [IDX_W-1:0]  cand_idx;
    logic              any_gnt;
    logic              sel_legal;
    logic              rd_issue;

    for (genvar g = 0; g < N_REQ; g++) begin : g_slice
        assign addr_a[g]  = addr[g*ADDR_W +: ADDR_W];
        assign wdata_a[g] = wdata[g*DATA_W +: DATA_W];
    end

    // Pick the winner: a locked owner that still requests, else the first
    // requester found scanning upward from rr_ptr.
    always_comb begin
        sel_idx  = '0;
        cand_idx = '0;
        any_gnt  = 1'b0;
        if (owner_vld && req[owner_idx]) begin
            sel_idx = owner_idx;
            any_gnt = 1'b1;
        end else begin
            for (int k = 0; k < N_REQ; k++) begin
                cand_idx = IDX_W'((int'(rr_ptr) + k) % N_REQ);
                if (!any_gnt && req[cand_idx]) begin
                    sel_idx = cand_idx;
                    any_gnt = 1'b1;
                end
            end
        end
    end

    // Illegal rows still consume the grant; they only suppress the write/read.
    assign sel_legal = ({1'b0, addr_a[sel_idx]} < DEPTH_L);
    assign rd_issue  = any_gnt & ~we[sel_idx] & sel_legal;

    assign gnt      = any_gnt ? (N_REQ'(1) << sel_idx) : '0;
    assign mem_we   = any_gnt & we[sel_idx] & sel_legal;
    assign mem_addr = any_gnt ? addr_a[sel_idx]  : '0;
    assign mem_din  = any_gnt ? wdata_a[sel_idx] : '0;
    assign rdata    = mem_dout;
    assign busy     = any_gnt | (|rvalid);

    // Rotate/lock bookkeeping, read-response tagging and the sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr    <= '0;
            owner_vld <= 1'b0;
            owner_idx <= '0;
            rvalid    <= '0;
            addr_err  <= 1'b0;
        end else begin
            rvalid <= rd_issue ? gnt : '0;
            if (any_gnt) begin
                if (!sel_legal) begin
                    addr_err <= 1'b1;
                end
                if (lock[sel_idx]) begin
                    owner_vld <= 1'b1;
                    owner_idx <= sel_idx;
                end else begin
                    owner_vld <= 1'b0;
                    rr_ptr    <= (sel_idx == LAST_IDX) ? '0 : sel_idx + IDX_W'(1);
                end
            end else begin
                // Owner dropped req and nobody else asked: the lock is gone.
                owner_vld <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_blur_mem_arbiter.sv
// Directed bench for blur_mem_arbiter with a behavioural 480-row SRAM model.
module tb_blur_mem_arbiter;

    localparam int N_REQ  = 3;
    localparam int ADDR_W = 9;
    localparam int DATA_W = 5120;
    localparam int DEPTH  = 480;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [N_REQ-1:0]         req, lock, we;
    logic [N_REQ*ADDR_W-1:0]  addr;
    logic [N_REQ*DATA_W-1:0]  wdata;
    logic [N_REQ-1:0]         gnt, rvalid;
    logic [DATA_W-1:0]        rdata;
    logic                     mem_we;
    logic [ADDR_W-1:0]        mem_addr;
    logic [DATA_W-1:0]        mem_din;
    logic [DATA_W-1:0]        mem_dout;
    logic                     busy, addr_err;

    logic [DATA_W-1:0] sram [0:DEPTH-1];
    logic [DATA_W-1:0] d5, d6, d7, da;
    logic [DATA_W-1:0] dexp [3];

    int n_tests = 0;
    int n_fail  = 0;

    blur_mem_arbiter #(
        .N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .lock(lock), .we(we),
        .addr(addr), .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout), .busy(busy), .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    // Synchronous single-port SRAM, one-cycle read latency.
    always @(posedge clk) begin
        if (mem_we && mem_addr < 9'd480) sram[mem_addr] <= mem_din;
        mem_dout <= (mem_addr < 9'd480) ? sram[mem_addr] : '0;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_data(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed[63:0]=%0h expected[63:0]=%0h", tag, obs[63:0], exp[63:0]);
        end
    endtask

    task automatic drive(input logic [2:0] r, input logic [2:0] l, input logic [2:0] w,
                         input logic [8:0] a0, input logic [8:0] a1, input logic [8:0] a2);
        req  = r;
        lock = l;
        we   = w;
        addr = {a2, a1, a0};
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        d5 = {160{32'h5555_0005}};
        d6 = {160{32'h6666_0006}};
        d7 = {160{32'h7777_0007}};
        da = {160{32'hA11C_E479}};
        dexp[0] = d5; dexp[1] = d6; dexp[2] = d7;

        rst_n = 1'b0;
        drive(3'b000, 3'b000, 3'b000, 9'd0, 9'd0, 9'd0);
        wdata = '0;
        #1;
        chk("rst_gnt",      64'(gnt),      64'd0);
        chk("rst_rvalid",   64'(rvalid),   64'd0);
        chk("rst_addr_err", 64'(addr_err), 64'd0);
        chk("rst_busy",     64'(busy),     64'd0);
        chk("rst_mem_we",   64'(mem_we),   64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Preload rows 5..7 through requester 2, then restart from reset state.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive(3'b100, 3'b000, 3'b100, 9'd0, 9'd0, 9'(5 + k));
            wdata[2*DATA_W +: DATA_W] = dexp[k];
            #1;
            chk("pre_mem_we", 64'(mem_we), 64'd1);
        end
        @(negedge clk);
        drive(3'b000, 3'b000, 3'b000, 9'd0, 9'd0, 9'd0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // All three read rows 5/6/7, no lock: grants rotate 0,1,2,0.
        @(negedge clk);
        drive(3'b111, 3'b000, 3'b000, 9'd5, 9'd6, 9'd7);
        for (int s = 0; s < 4; s++) begin
            #1;
            chk("rr_gnt",  64'(gnt),      64'(3'b001 << (s % 3)));
            chk("rr_addr", 64'(mem_addr), 64'(5 + (s % 3)));
            chk("rr_busy", 64'(busy),     64'd1);
            @(posedge clk); #1;
            chk("rr_rvalid", 64'(rvalid), 64'(3'b001 << (s % 3)));
            chk_data("rr_rdata", rdata, dexp[s % 3]);
            @(negedge clk);
        end

        // Requester 1 locks for 4 cycles, then drops req; 2 then 0 follow.
        lock = 3'b010;
        for (int s = 0; s < 4; s++) begin
            #1;
            chk("lock_gnt", 64'(gnt), 64'b010);
            @(posedge clk); #1;
            chk("lock_rvalid", 64'(rvalid), 64'b010);
            chk_data("lock_rdata", rdata, d6);
            @(negedge clk);
        end
        drive(3'b101, 3'b000, 3'b000, 9'd5, 9'd6, 9'd7);
        #1;
        chk("rel_gnt2", 64'(gnt), 64'b100);
        @(posedge clk); #1;
        chk("rel_rvalid2", 64'(rvalid), 64'b100);
        chk_data("rel_rdata2", rdata, d7);
        @(negedge clk); #1;
        chk("rel_gnt0", 64'(gnt), 64'b001);
        @(posedge clk); #1;
        chk("rel_rvalid0", 64'(rvalid), 64'b001);
        chk_data("rel_rdata0", rdata, d5);

        // Requester 0 writes row 479, requester 2 reads it back next cycle.
        @(negedge clk);
        drive(3'b001, 3'b000, 3'b001, 9'd479, 9'd0, 9'd0);
        wdata[0 +: DATA_W] = da;
        #1;
        chk("wr_gnt",    64'(gnt),      64'b001);
        chk("wr_mem_we", 64'(mem_we),   64'd1);
        chk("wr_addr",   64'(mem_addr), 64'd479);
        @(posedge clk); #1;
        chk("wr_rvalid", 64'(rvalid), 64'd0);
        @(negedge clk);
        drive(3'b100, 3'b000, 3'b000, 9'd0, 9'd0, 9'd479);
        #1;
        chk("rb_gnt",    64'(gnt),    64'b100);
        chk("rb_mem_we", 64'(mem_we), 64'd0);
        @(posedge clk); #1;
        chk("rb_rvalid", 64'(rvalid), 64'b100);
        chk_data("rb_rdata", rdata, da);

        // Requester 2 writes illegal row 480.
        @(negedge clk);
        drive(3'b100, 3'b000, 3'b100, 9'd0, 9'd0, 9'd480);
        wdata[2*DATA_W +: DATA_W] = d5;
        #1;
        chk("ill_gnt",      64'(gnt),      64'b100);
        chk("ill_mem_we",   64'(mem_we),   64'd0);
        chk("ill_err_pre",  64'(addr_err), 64'd0);
        @(posedge clk); #1;
        chk("ill_err_set",  64'(addr_err), 64'd1);
        chk("ill_rvalid",   64'(rvalid),   64'd0);
        @(negedge clk);
        drive(3'b000, 3'b000, 3'b000, 9'd0, 9'd0, 9'd0);
        @(posedge clk); #1;
        chk("ill_err_hold", 64'(addr_err), 64'd1);
        @(negedge clk);
        drive(3'b010, 3'b000, 3'b000, 9'd0, 9'd479, 9'd0);
        #1;
        chk("post_ill_gnt", 64'(gnt), 64'b010);
        @(posedge clk); #1;
        chk("post_ill_rvalid", 64'(rvalid),   64'b010);
        chk_data("post_ill_rdata", rdata, da);
        chk("post_ill_err",    64'(addr_err), 64'd1);

        // Requester 1 takes a lock (rr_ptr is 2, so 0 would win without it).
        @(negedge clk);
        drive(3'b010, 3'b010, 3'b000, 9'd5, 9'd6, 9'd0);
        #1;
        chk("mrst_gnt_a", 64'(gnt), 64'b010);
        @(negedge clk);
        drive(3'b011, 3'b010, 3'b000, 9'd5, 9'd6, 9'd0);
        #1;
        chk("mrst_gnt_b", 64'(gnt), 64'b010);
        @(posedge clk); #1;
        chk("mrst_rvalid_pre", 64'(rvalid), 64'b010);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_rvalid_clr", 64'(rvalid),   64'd0);
        chk("mrst_err_clr",    64'(addr_err), 64'd0);
        chk("mrst_gnt_prio",   64'(gnt),      64'b001);
        @(posedge clk); #1;
        chk("mrst_rvalid_hold", 64'(rvalid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        lock  = 3'b000;
        #1;
        chk("mrst_gnt_after", 64'(gnt), 64'b001);
        @(posedge clk); #1;
        chk("mrst_rvalid_after", 64'(rvalid), 64'b001);
        chk_data("mrst_rdata_after", rdata, d5);

        // Idle: nothing requested for 10 cycles.
        @(negedge clk);
        drive(3'b000, 3'b000, 3'b000, 9'd0, 9'd0, 9'd0);
        @(posedge clk);
        for (int s = 0; s < 10; s++) begin
            @(negedge clk); #1;
            chk("idle_gnt",    64'(gnt),      64'd0);
            chk("idle_mem_we", 64'(mem_we),   64'd0);
            chk("idle_addr",   64'(mem_addr), 64'd0);
            chk("idle_busy",   64'(busy),     64'd0);
            chk("idle_rvalid", 64'(rvalid),   64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
